// File: rtl/rapids_run_ctrl.sv
// -----------------------------------------------------------------------------
// rapids_run_ctrl
// Run-control sequencer for the rapids core. Owns the PC and go/halt handling,
// and sequences each instruction through FETCH -> EXEC -> (MEM) -> commit.
// It also captures the first fault (cause + PC), counts retired instructions
// (saturating), and applies branch redirects at commit.
//
// Configuration macro: RAPIDS_SINGLE_STEP_EN
//   defined   : adds input 'step'. A step pulse while HALTED runs exactly one
//               instruction and then returns to HALTED.
//   undefined : no step port. HALTED exits only via go.
//
// Ports
//   clk, reset             clock; asynchronous active-high reset
//   step                   single-step request (only when RAPIDS_SINGLE_STEP_EN)
//   go, halt               run / stop requests (levels). halt wins over go.
//   wait_instr, instr_segv MMU instruction-side status
//   wait_data, data_segv   MMU data-side status
//   is_mem, branch_taken,
//   branch_target          decode results, valid in EXEC
//   pc                     current fetch PC
//   fetch_req/exec_en/
//   mem_req                state strobes
//   commit                 one-cycle retire pulse
//   state                  IDLE=0 FETCH=1 EXEC=2 MEM=3 HALTED=4 FAULT=5
//   fault_cause, fault_pc  latched fault information
//   retired                retired-instruction count (saturating)
// -----------------------------------------------------------------------------
module rapids_run_ctrl #(
  parameter int               ADDR_W      = 32,
  parameter int               INSTR_BYTES = 4,
  parameter int               CNT_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              reset,
`ifdef RAPIDS_SINGLE_STEP_EN
  input  logic              step,
`endif
  input  logic              go,
  input  logic              halt,
  input  logic              wait_instr,
  input  logic              instr_segv,
  input  logic              wait_data,
  input  logic              data_segv,
  input  logic              is_mem,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_req,
  output logic              exec_en,
  output logic              mem_req,
  output logic              commit,
  output logic [2:0]        state,
  output logic [1:0]        fault_cause,
  output logic [ADDR_W-1:0] fault_pc,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALTED = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   pc_r;
  logic [ADDR_W-1:0]   fault_pc_r;
  logic [1:0]          fault_cause_r;
  logic [CNT_W-1:0]    retired_r;
  logic                commit_r;
  logic                br_taken_r;
  logic [ADDR_W-1:0]   br_target_r;
  logic                step_armed_r;

  logic                do_commit_s;
  logic [ADDR_W-1:0]   seq_pc_s;
  logic [ADDR_W-1:0]   commit_pc_s;
  state_t              commit_next_s;
  logic                step_go_s;

`ifdef RAPIDS_SINGLE_STEP_EN
  assign step_go_s = step & ~go;
`else
  assign step_go_s = 1'b0;
`endif

  // Retire decision, next PC and post-retire state for the current cycle.
  always_comb begin
    seq_pc_s    = pc_r + ADDR_W'(INSTR_BYTES);
    do_commit_s = 1'b0;
    commit_pc_s = seq_pc_s;
    if (state_r == S_EXEC) begin
      do_commit_s = ~is_mem;
      commit_pc_s = branch_taken ? branch_target : seq_pc_s;
    end else if (state_r == S_MEM) begin
      // A memory instruction's branch decision was captured in EXEC.
      do_commit_s = ~data_segv & ~wait_data;
      commit_pc_s = br_taken_r ? br_target_r : seq_pc_s;
    end else begin
      do_commit_s = 1'b0;
      commit_pc_s = seq_pc_s;
    end
    if (halt || step_armed_r) begin
      commit_next_s = S_HALTED;
    end else begin
      commit_next_s = S_FETCH;
    end
  end

  // Sequencer state, PC, fault capture and retire counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= S_IDLE;
      pc_r          <= RESET_PC;
      fault_pc_r    <= '0;
      fault_cause_r <= 2'b00;
      retired_r     <= '0;
      commit_r      <= 1'b0;
      br_taken_r    <= 1'b0;
      br_target_r   <= '0;
      step_armed_r  <= 1'b0;
    end else begin
      commit_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (go && !halt) state_r <= S_FETCH;
          else             state_r <= S_IDLE;
        end
        S_FETCH: begin
          if (halt) begin
            state_r      <= S_HALTED;
            step_armed_r <= 1'b0;
          end else if (instr_segv) begin
            state_r       <= S_FAULT;
            fault_cause_r <= 2'b01;
            fault_pc_r    <= pc_r;
            step_armed_r  <= 1'b0;
          end else if (!wait_instr) begin
            state_r <= S_EXEC;
          end else begin
            state_r <= S_FETCH;
          end
        end
        S_EXEC: begin
          br_taken_r  <= branch_taken;
          br_target_r <= branch_target;
          if (is_mem) state_r <= S_MEM;
          else        state_r <= commit_next_s;
        end
        S_MEM: begin
          if (data_segv) begin
            state_r       <= S_FAULT;
            fault_cause_r <= 2'b10;
            fault_pc_r    <= pc_r;
            step_armed_r  <= 1'b0;
          end else if (!wait_data) begin
            state_r <= commit_next_s;
          end else begin
            state_r <= S_MEM;
          end
        end
        S_HALTED: begin
          if (go && !halt) begin
            state_r <= S_FETCH;
          end else if (step_go_s) begin
            state_r      <= S_FETCH;
            step_armed_r <= 1'b1;
          end else begin
            state_r <= S_HALTED;
          end
        end
        S_FAULT: begin
          // Resume from a fault restarts at RESET_PC; fault_pc is kept for software.
          if (go && !halt) begin
            state_r       <= S_FETCH;
            pc_r          <= RESET_PC;
            fault_cause_r <= 2'b00;
          end else begin
            state_r <= S_FAULT;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase

      // commit is registered, so it pulses in the cycle where pc/retired show the new values.
      if (do_commit_s) begin
        commit_r     <= 1'b1;
        pc_r         <= commit_pc_s;
        step_armed_r <= 1'b0;
        if (retired_r != {CNT_W{1'b1}}) retired_r <= retired_r + CNT_W'(1);
        else                            retired_r <= retired_r;
      end else begin
        commit_r <= 1'b0;
      end
    end
  end

  assign pc          = pc_r;
  assign fetch_req   = (state_r == S_FETCH);
  assign exec_en     = (state_r == S_EXEC);
  assign mem_req     = (state_r == S_MEM);
  assign commit      = commit_r;
  assign state       = state_r;
  assign fault_cause = fault_cause_r;
  assign fault_pc    = fault_pc_r;
  assign retired     = retired_r;

endmodule

// File: tb/tb_rapids_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rapids_run_ctrl
// Directed self-checking bench for rapids_run_ctrl. Inputs change 1 time unit
// after a rising edge; outputs are checked at that same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_rapids_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
`ifdef RAPIDS_SINGLE_STEP_EN
  logic        step;
`endif
  logic        go, halt, wait_instr, instr_segv, wait_data, data_segv;
  logic        is_mem, branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic        fetch_req, exec_en, mem_req, commit;
  logic [2:0]  state;
  logic [1:0]  fault_cause;
  logic [31:0] fault_pc;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rapids_run_ctrl dut (
    .clk(clk), .reset(reset),
`ifdef RAPIDS_SINGLE_STEP_EN
    .step(step),
`endif
    .go(go), .halt(halt), .wait_instr(wait_instr), .instr_segv(instr_segv),
    .wait_data(wait_data), .data_segv(data_segv), .is_mem(is_mem),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pc(pc), .fetch_req(fetch_req), .exec_en(exec_en), .mem_req(mem_req),
    .commit(commit), .state(state), .fault_cause(fault_cause),
    .fault_pc(fault_pc), .retired(retired)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; halt = 1'b0; wait_instr = 1'b0; instr_segv = 1'b0;
    wait_data = 1'b0; data_segv = 1'b0; is_mem = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0;
`ifdef RAPIDS_SINGLE_STEP_EN
    step = 1'b0;
`endif
    tick(); tick();
    reset = 1'b0;
    tick();
    check_eq("rst_state", state, 3'd0);
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_retired", retired, 32'd0);
    check_eq("rst_cause", fault_cause, 2'b00);
    check_eq("rst_strobes", {fetch_req, exec_en, mem_req, commit}, 4'b0000);

    // 1: four sequential non-memory instructions, 2 cycles each
    go = 1'b1;
    tick();
    go = 1'b0;
    check_eq("t1_fetch", state, 3'd1);
    check_eq("t1_fetch_req", fetch_req, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_eq("t1_exec", state, 3'd2);
      check_eq("t1_exec_en", exec_en, 1'b1);
      check_eq("t1_nocommit", commit, 1'b0);
      tick();
      check_eq("t1_commit", commit, 1'b1);
      check_eq("t1_pc", pc, 32'(4 * i));
      check_eq("t1_retired", retired, 32'(i));
      check_eq("t1_back_fetch", state, 3'd1);
    end

    // 2: memory instruction, wait_data for 3 MEM cycles -> 4 MEM cycles
    is_mem = 1'b1; wait_data = 1'b1;
    tick();
    check_eq("t2_exec", state, 3'd2);
    tick();
    is_mem = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_eq("t2_mem", state, 3'd3);
      check_eq("t2_mem_req", mem_req, 1'b1);
      check_eq("t2_nocommit", commit, 1'b0);
      tick();
    end
    check_eq("t2_mem4", state, 3'd3);
    wait_data = 1'b0;
    tick();
    check_eq("t2_commit", commit, 1'b1);
    check_eq("t2_pc", pc, 32'd20);
    check_eq("t2_retired", retired, 32'd5);
    check_eq("t2_fetch", state, 3'd1);

    // 3: branch redirect, wrap-around, and latched target for a memory branch
    tick();
    branch_taken = 1'b1; branch_target = 32'h100;
    tick();
    check_eq("t3_br_pc", pc, 32'h100);
    tick();
    branch_target = 32'hFFFF_FFFC;
    tick();
    check_eq("t3_br_pc2", pc, 32'hFFFF_FFFC);
    branch_taken = 1'b0;
    tick(); tick();
    check_eq("t3_wrap_pc", pc, 32'h0);
    check_eq("t3_retired", retired, 32'd8);
    is_mem = 1'b1; branch_taken = 1'b1; branch_target = 32'h8;
    tick();
    tick();
    check_eq("t3_mem", state, 3'd3);
    is_mem = 1'b0; branch_taken = 1'b0; branch_target = 32'h99;
    tick();
    check_eq("t3_membr_pc", pc, 32'h8);
    check_eq("t3_retired2", retired, 32'd9);

    // 4: data fault at pc 0x8, sticky, halt beats go, go restarts at RESET_PC
    is_mem = 1'b1;
    tick();
    tick();
    is_mem = 1'b0; data_segv = 1'b1;
    tick();
    data_segv = 1'b0;
    check_eq("t4_state", state, 3'd5);
    check_eq("t4_cause", fault_cause, 2'b10);
    check_eq("t4_fpc", fault_pc, 32'h8);
    check_eq("t4_retired", retired, 32'd9);
    check_eq("t4_commit", commit, 1'b0);
    tick();
    check_eq("t4_sticky", state, 3'd5);
    go = 1'b1; halt = 1'b1;
    tick();
    check_eq("t4_halt_wins", state, 3'd5);
    halt = 1'b0;
    tick();
    go = 1'b0;
    check_eq("t4_resume", state, 3'd1);
    check_eq("t4_resume_pc", pc, 32'h0);
    check_eq("t4_cause_clr", fault_cause, 2'b00);
    check_eq("t4_fpc_kept", fault_pc, 32'h8);

    // instruction fault: segv takes priority over a valid instruction
    instr_segv = 1'b1;
    tick();
    instr_segv = 1'b0;
    check_eq("t4i_state", state, 3'd5);
    check_eq("t4i_cause", fault_cause, 2'b01);
    check_eq("t4i_fpc", fault_pc, 32'h0);
    go = 1'b1;
    tick();
    go = 1'b0;
    check_eq("t4i_resume", state, 3'd1);

    // 5: halt during MEM completes the instruction, then HALTED
    is_mem = 1'b1; wait_data = 1'b1;
    tick();
    tick();
    is_mem = 1'b0; halt = 1'b1;
    tick();
    check_eq("t5_mem_ignores_halt", state, 3'd3);
    wait_data = 1'b0;
    tick();
    check_eq("t5_commit", commit, 1'b1);
    check_eq("t5_halted", state, 3'd4);
    check_eq("t5_pc", pc, 32'h4);
    check_eq("t5_retired", retired, 32'd10);
    go = 1'b1;
    tick();
    check_eq("t5_gohalt", state, 3'd4);
    halt = 1'b0;
    tick();
    go = 1'b0;
    check_eq("t5_resume", state, 3'd1);
    check_eq("t5_resume_pc", pc, 32'h4);
    // halt in FETCH aborts the fetch, pc unchanged
    wait_instr = 1'b1; halt = 1'b1;
    tick();
    halt = 1'b0; wait_instr = 1'b0;
    check_eq("t5_fetch_abort", state, 3'd4);
    check_eq("t5_abort_pc", pc, 32'h4);
    check_eq("t5_abort_retired", retired, 32'd10);
    tick();
    check_eq("t5_stays_halted", state, 3'd4);

`ifdef RAPIDS_SINGLE_STEP_EN
    // single step: exactly one instruction, then back to HALTED
    step = 1'b1;
    tick();
    step = 1'b0;
    check_eq("ss_fetch", state, 3'd1);
    tick();
    tick();
    check_eq("ss_halted", state, 3'd4);
    check_eq("ss_retired", retired, 32'd11);
    check_eq("ss_pc", pc, 32'h8);
    tick();
    check_eq("ss_stays", state, 3'd4);
`endif

    // 6: asynchronous reset in the middle of MEM
    go = 1'b1;
    tick();
    go = 1'b0; is_mem = 1'b1; wait_data = 1'b1;
    tick();
    tick();
    check_eq("t6_in_mem", state, 3'd3);
    #2;
    reset = 1'b1;
    #1;
    check_eq("t6_state", state, 3'd0);
    check_eq("t6_pc", pc, 32'h0);
    check_eq("t6_retired", retired, 32'd0);
    check_eq("t6_mem_req", mem_req, 1'b0);
    tick();
    reset = 1'b0; is_mem = 1'b0; wait_data = 1'b0;
    tick();
    check_eq("t6_idle_after", state, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
